// File: rtl/life_pkg.sv
// Shared types and default sizing for the 8x8 toroidal life engine.
package life_pkg;

  localparam int N_DEF     = 8;
  localparam int CNT_W_DEF = 16;
  localparam int DIV_W_DEF = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/life_next_state.sv
// Purely combinational toroidal next-generation of an N*N life board.
// Cell (i,j) lives at bit i*N+j; the board wraps at every edge.
module life_next_state
  import life_pkg::*;
#(
  parameter int N = N_DEF
) (
  input  logic [N*N-1:0] board_i,
  output logic [N*N-1:0] next_o
);

  for (genvar i = 0; i < N; i++) begin : g_row
    for (genvar j = 0; j < N; j++) begin : g_col
      // Wrapped neighbour coordinates, resolved at elaboration time.
      localparam int IU = (i + N - 1) % N;
      localparam int ID = (i + 1) % N;
      localparam int JL = (j + N - 1) % N;
      localparam int JR = (j + 1) % N;

      logic [3:0] nbr;

      assign nbr = {3'b000, board_i[IU*N+JL]} + {3'b000, board_i[IU*N+j]} +
                   {3'b000, board_i[IU*N+JR]} + {3'b000, board_i[i*N+JL]} +
                   {3'b000, board_i[i*N+JR]}  + {3'b000, board_i[ID*N+JL]} +
                   {3'b000, board_i[ID*N+j]}  + {3'b000, board_i[ID*N+JR]};

      assign next_o[i*N+j] = (nbr == 4'd3) || ((nbr == 4'd2) && board_i[i*N+j]);
    end
  end

endmodule

// File: rtl/life_gen_ctrl.sv
// Generation sequencer for the toroidal life engine: board register, seed loading and paced runs.
// Optional still-life termination is built when LIFE_STABLE_DETECT_EN is defined.
module life_gen_ctrl
  import life_pkg::*;
#(
  parameter int N     = N_DEF,
  parameter int CNT_W = CNT_W_DEF,
  parameter int DIV_W = DIV_W_DEF
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 load_valid,
  input  logic [$clog2(N)-1:0] load_row,
  input  logic [N-1:0]         load_data,
  output logic                 load_ready,
  input  logic                 start,
  input  logic                 stop,
  input  logic                 step,
  input  logic [CNT_W-1:0]     gen_limit,
  input  logic [DIV_W-1:0]     period,
  output logic                 busy,
  output logic                 done,
  output logic                 extinct,
  output logic                 stable,
  output logic [CNT_W-1:0]     gen_count,
  output logic [N*N-1:0]       board
);

  localparam int RW = $clog2(N);

  state_e             state_q, state_d;
  logic [N*N-1:0]     board_q, board_d;
  logic [CNT_W-1:0]   gen_q, gen_d;
  logic [DIV_W-1:0]   div_q, div_d;
  logic               done_q, done_d;
  logic               extinct_q, extinct_d;
  logic               stable_q, stable_d;

  logic [N*N-1:0]     next_board;
  logic [CNT_W-1:0]   gen_inc;
  logic               next_zero;
  logic               is_still;
  logic               do_commit;

  life_next_state #(.N(N)) u_next (
    .board_i (board_q),
    .next_o  (next_board)
  );

  assign gen_inc   = gen_q + CNT_W'(1);
  assign next_zero = (next_board == '0);

`ifdef LIFE_STABLE_DETECT_EN
  assign is_still = (next_board == board_q);
`else
  assign is_still = 1'b0;
`endif

  // NOTE: every signal written here gets a default first, so no path leaves a latch behind.
  always_comb begin
    state_d   = state_q;
    board_d   = board_q;
    gen_d     = gen_q;
    div_d     = div_q;
    done_d    = done_q;
    extinct_d = extinct_q;
    stable_d  = stable_q;
    do_commit = 1'b0;

    case (state_q)
      ST_IDLE, ST_DONE: begin
        // Load beats start beats step when they collide.
        if (load_valid) begin
          for (int r = 0; r < N; r++) begin
            if (load_row == RW'(r)) board_d[r*N +: N] = load_data;
          end
          state_d   = ST_IDLE;
          done_d    = 1'b0;
          extinct_d = 1'b0;
          stable_d  = 1'b0;
        end else if (start) begin
          state_d   = ST_RUN;
          gen_d     = '0;
          div_d     = '0;
          done_d    = 1'b0;
          extinct_d = 1'b0;
          stable_d  = 1'b0;
        end else if (step) begin
          do_commit = 1'b1;
          state_d   = ST_IDLE;
          done_d    = 1'b0;
        end
      end

      ST_RUN: begin
        if (stop) begin
          state_d = ST_IDLE;
        end else if (div_q == period) begin
          do_commit = 1'b1;
          div_d     = '0;
          if (next_zero || is_still || ((gen_limit != '0) && (gen_inc == gen_limit))) begin
            state_d = ST_DONE;
            done_d  = 1'b1;
          end
        end else begin
          div_d = div_q + DIV_W'(1);
        end
      end

      default: state_d = ST_IDLE;
    endcase

    if (do_commit) begin
      board_d   = next_board;
      gen_d     = gen_inc;
      extinct_d = next_zero;
      stable_d  = is_still;
    end
  end

  // NOTE: state updates use non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      board_q   <= '0;
      gen_q     <= '0;
      div_q     <= '0;
      done_q    <= 1'b0;
      extinct_q <= 1'b0;
      stable_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      board_q   <= board_d;
      gen_q     <= gen_d;
      div_q     <= div_d;
      done_q    <= done_d;
      extinct_q <= extinct_d;
      stable_q  <= stable_d;
    end
  end

  assign load_ready = (state_q != ST_RUN);
  assign busy       = (state_q == ST_RUN);
  assign done       = done_q;
  assign extinct    = extinct_q;
  assign stable     = stable_q;
  assign gen_count  = gen_q;
  assign board      = board_q;

endmodule

// File: tb/tb_life_gen_ctrl.sv
// Directed bench for life_gen_ctrl: seeds, paced runs, termination, stop, step and reset.
module tb_life_gen_ctrl;

  localparam logic [63:0] BLINK_H = 64'h0000_0000_1C00_0000;
  localparam logic [63:0] BLINK_V = 64'h0000_0008_0808_0000;
  localparam logic [63:0] BLOCK   = 64'h0000_0018_1800_0000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        load_valid = 1'b0;
  logic [2:0]  load_row = '0;
  logic [7:0]  load_data = '0;
  logic        load_ready;
  logic        start = 1'b0;
  logic        stop = 1'b0;
  logic        step = 1'b0;
  logic [15:0] gen_limit = '0;
  logic [7:0]  period = '0;
  logic        busy, done, extinct, stable;
  logic [15:0] gen_count;
  logic [63:0] board;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  life_gen_ctrl dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_valid (load_valid),
    .load_row   (load_row),
    .load_data  (load_data),
    .load_ready (load_ready),
    .start      (start),
    .stop       (stop),
    .step       (step),
    .gen_limit  (gen_limit),
    .period     (period),
    .busy       (busy),
    .done       (done),
    .extinct    (extinct),
    .stable     (stable),
    .gen_count  (gen_count),
    .board      (board)
  );

  // Inputs change and outputs are sampled on the falling edge.
  task automatic edges(input int n);
    repeat (n) @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    #3;
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic load(input logic [2:0] row, input logic [7:0] data);
    load_valid = 1'b1; load_row = row; load_data = data;
    edges(1);
    load_valid = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    edges(1);
    start = 1'b0;
  endtask

  task automatic test_reset();
    tests++; if (board !== 64'h0) begin fails++; $display("FAIL rst_board: got %h want 0", board); end
    tests++; if (gen_count !== 16'd0) begin fails++; $display("FAIL rst_gen: got %0d want 0", gen_count); end
    tests++; if ({load_ready, busy, done, extinct, stable} !== 5'b10000) begin
      fails++; $display("FAIL rst_flags: got %b want 10000", {load_ready, busy, done, extinct, stable}); end
  endtask

  task automatic test_blinker_limit();
    do_reset();
    load(3'd3, 8'b0001_1100);
    tests++; if (board !== BLINK_H) begin fails++; $display("FAIL seed_load: got %h want %h", board, BLINK_H); end
    period = 8'd0; gen_limit = 16'd4;
    pulse_start();
    tests++; if ({busy, load_ready, gen_count} !== {2'b10, 16'd0}) begin
      fails++; $display("FAIL blink_run: busy %b ready %b gen %0d want 1 0 0", busy, load_ready, gen_count); end
    edges(1);
    tests++; if (board !== BLINK_V || gen_count !== 16'd1) begin
      fails++; $display("FAIL blink_gen1: got %h/%0d want %h/1", board, gen_count, BLINK_V); end
    edges(2);
    tests++; if ({busy, done, gen_count} !== {2'b10, 16'd3}) begin
      fails++; $display("FAIL blink_gen3: busy %b done %b gen %0d want 1 0 3", busy, done, gen_count); end
    edges(1);
    tests++; if ({busy, done, extinct, load_ready, gen_count} !== {4'b0101, 16'd4}) begin
      fails++; $display("FAIL blink_done: b%b d%b e%b r%b gen %0d want 0 1 0 1 4", busy, done, extinct, load_ready, gen_count); end
    tests++; if (board !== BLINK_H) begin fails++; $display("FAIL blink_board: got %h want %h", board, BLINK_H); end
  endtask

  task automatic test_extinct();
    do_reset();
    load(3'd0, 8'h01);
    period = 8'd0; gen_limit = 16'd0;
    pulse_start();
    edges(1);
    tests++; if ({busy, done, extinct, board, gen_count} !== {3'b011, 64'h0, 16'd1}) begin
      fails++; $display("FAIL ext_done: b%b d%b e%b board %h gen %0d want 0 1 1 0 1", busy, done, extinct, board, gen_count); end
    step = 1'b1;
    edges(1);
    step = 1'b0;
    tests++; if ({busy, done, extinct, gen_count} !== {3'b001, 16'd2}) begin
      fails++; $display("FAIL ext_step: b%b d%b e%b gen %0d want 0 0 1 2", busy, done, extinct, gen_count); end
    load(3'd7, 8'h80);
    tests++; if ({extinct, board} !== {1'b0, 64'h8000_0000_0000_0000}) begin
      fails++; $display("FAIL ext_load: e%b board %h want 0 8000000000000000", extinct, board); end
  endtask

  task automatic test_still_life();
    do_reset();
    load(3'd3, 8'h18);
    load(3'd4, 8'h18);
    period = 8'd0; gen_limit = 16'd0;
    pulse_start();
    edges(1);
`ifdef LIFE_STABLE_DETECT_EN
    tests++; if ({busy, done, stable, extinct, gen_count, board} !== {4'b0110, 16'd1, BLOCK}) begin
      fails++; $display("FAIL still_stop: b%b d%b s%b e%b gen %0d board %h", busy, done, stable, extinct, gen_count, board); end
`else
    edges(5);
    tests++; if ({busy, done, stable, gen_count, board} !== {3'b100, 16'd6, BLOCK}) begin
      fails++; $display("FAIL still_run: b%b d%b s%b gen %0d board %h", busy, done, stable, gen_count, board); end
    stop = 1'b1;
    edges(1);
    stop = 1'b0;
    tests++; if ({busy, done, gen_count} !== {2'b00, 16'd6}) begin
      fails++; $display("FAIL still_halt: b%b d%b gen %0d want 0 0 6", busy, done, gen_count); end
`endif
  endtask

  task automatic test_period();
    do_reset();
    load(3'd3, 8'b0001_1100);
    period = 8'd2; gen_limit = 16'd3;
    pulse_start();
    edges(2);
    tests++; if (gen_count !== 16'd0) begin fails++; $display("FAIL per_t2: gen %0d want 0", gen_count); end
    edges(1);
    tests++; if (gen_count !== 16'd1 || board !== BLINK_V) begin
      fails++; $display("FAIL per_t3: gen %0d board %h want 1 %h", gen_count, board, BLINK_V); end
    edges(2);
    tests++; if (gen_count !== 16'd1) begin fails++; $display("FAIL per_t5: gen %0d want 1", gen_count); end
    edges(1);
    tests++; if (gen_count !== 16'd2) begin fails++; $display("FAIL per_t6: gen %0d want 2", gen_count); end
    edges(2);
    tests++; if ({busy, done, gen_count} !== {2'b10, 16'd2}) begin
      fails++; $display("FAIL per_t8: b%b d%b gen %0d want 1 0 2", busy, done, gen_count); end
    edges(1);
    tests++; if ({busy, done, gen_count, board} !== {2'b01, 16'd3, BLINK_V}) begin
      fails++; $display("FAIL per_t9: b%b d%b gen %0d board %h", busy, done, gen_count, board); end
  endtask

  task automatic test_stop();
    do_reset();
    load(3'd3, 8'b0001_1100);
    period = 8'd3; gen_limit = 16'd0;
    pulse_start();
    load_valid = 1'b1; load_row = 3'd0; load_data = 8'hFF;
    tests++; if (load_ready !== 1'b0) begin fails++; $display("FAIL stop_ready: got %b want 0", load_ready); end
    edges(1);
    load_valid = 1'b0;
    start = 1'b1;
    edges(3);
    start = 1'b0;
    tests++; if ({gen_count, board} !== {16'd1, BLINK_V}) begin
      fails++; $display("FAIL stop_gen1: gen %0d board %h want 1 %h", gen_count, board, BLINK_V); end
    edges(3);
    stop = 1'b1;
    edges(1);
    stop = 1'b0;
    tests++; if ({busy, done, gen_count, board} !== {2'b00, 16'd1, BLINK_V}) begin
      fails++; $display("FAIL stop_abort: b%b d%b gen %0d board %h", busy, done, gen_count, board); end
  endtask

  task automatic test_step_and_reset();
    do_reset();
    load(3'd3, 8'b0001_1100);
    step = 1'b1;
    edges(1);
    step = 1'b0;
    tests++; if ({busy, load_ready, gen_count, board} !== {2'b01, 16'd1, BLINK_V}) begin
      fails++; $display("FAIL step1: b%b r%b gen %0d board %h", busy, load_ready, gen_count, board); end
    step = 1'b1;
    edges(1);
    step = 1'b0;
    tests++; if ({gen_count, board} !== {16'd2, BLINK_H}) begin
      fails++; $display("FAIL step2: gen %0d board %h want 2 %h", gen_count, board, BLINK_H); end
    load_valid = 1'b1; load_row = 3'd0; load_data = 8'h01;
    start = 1'b1; step = 1'b1;
    edges(1);
    load_valid = 1'b0; start = 1'b0; step = 1'b0;
    tests++; if ({busy, gen_count, board} !== {1'b0, 16'd2, BLINK_H | 64'h1}) begin
      fails++; $display("FAIL prio_load: b%b gen %0d board %h", busy, gen_count, board); end
    period = 8'd0; gen_limit = 16'd0;
    load(3'd0, 8'h00);
    pulse_start();
    edges(2);
    rst_n = 1'b0;
    #1;
    tests++; if ({board, gen_count, load_ready, busy} !== {64'h0, 16'd0, 2'b10}) begin
      fails++; $display("FAIL async_rst: board %h gen %0d r%b b%b", board, gen_count, load_ready, busy); end
    rst_n = 1'b1;
  endtask

  initial begin
    #2 rst_n = 1'b1;
    @(negedge clk);
    test_reset();
    test_blinker_limit();
    test_extinct();
    test_still_life();
    test_period();
    test_stop();
    test_step_and_reset();
    edges(1);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
